// File: rtl/rtc_bus_master.sv
// Multiplexed address/data bus master for the RTC: one write per wr_req edge, periodic 9-register read sweeps.
// Optional build macro RTC_TRANSFER_CMD_EN appends a transfer-command access (0xF0 -> 0xF0) after each write and sweep.
module rtc_bus_master #(
    parameter int T_PH     = 4,
    parameter int READ_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [8:0] habilita,
    input  logic [7:0] ano,
    input  logic [7:0] mes,
    input  logic [7:0] dia,
    input  logic [7:0] horas,
    input  logic [7:0] minutos,
    input  logic [7:0] segundos,
    input  logic [7:0] ht,
    input  logic [7:0] mt,
    input  logic [7:0] st,
    output logic [7:0] anole,
    output logic [7:0] mesle,
    output logic [7:0] diale,
    output logic [7:0] horasle,
    output logic [7:0] minutosle,
    output logic [7:0] segundosle,
    output logic [7:0] htle,
    output logic [7:0] mtle,
    output logic [7:0] stle,
    output logic       listo_es,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_REC, S_DATA, S_DATA_REC, S_GAP} state_t;

`ifdef RTC_TRANSFER_CMD_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif
    localparam logic [7:0]  CMD_BYTE = 8'hF0;
    localparam logic [7:0]  PH_LAST  = 8'(T_PH - 1);
    localparam logic [31:0] DIV_LAST = 32'(READ_DIV - 1);

    function automatic logic [7:0] f_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    f_addr = 8'h26;
            4'd1:    f_addr = 8'h25;
            4'd2:    f_addr = 8'h24;
            4'd3:    f_addr = 8'h23;
            4'd4:    f_addr = 8'h22;
            4'd5:    f_addr = 8'h21;
            4'd6:    f_addr = 8'h43;
            4'd7:    f_addr = 8'h42;
            default: f_addr = 8'h41;
        endcase
    endfunction

    function automatic logic [3:0] f_enc(input logic [8:0] oh);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 9; i++)
            if (oh[i]) v = 4'(i);
        return v;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic        r_is_wr, w_is_wr_nxt;
    logic        r_cmd, w_cmd_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic        w_take_wr, w_take_sweep, w_wr_done, w_sample;
    logic        r_wr_req_d, r_pend, r_busy, r_sweep_pend;
    logic [3:0]  r_cap_idx;
    logic [7:0]  r_cap_data;
    logic [31:0] r_tmr;
    logic [7:0]  r_le [9];
    logic [7:0]  w_vals [9];
    logic        w_rise, w_onehot, w_wrdir;
    logic [7:0]  w_addr_nxt, w_dbyte_nxt;
    logic        w_cs_n_nxt, w_rd_n_nxt, w_wr_n_nxt, w_a_d_nxt, w_oe_nxt;
    logic [7:0]  w_out_nxt;
    logic        r_cs_n, r_rd_n, r_wr_n, r_a_d, r_oe;
    logic [7:0]  r_out;

    always_comb begin
        w_vals[0] = ano;     w_vals[1] = mes;      w_vals[2] = dia;
        w_vals[3] = horas;   w_vals[4] = minutos;  w_vals[5] = segundos;
        w_vals[6] = ht;      w_vals[7] = mt;       w_vals[8] = st;
    end

    assign w_rise   = wr_req & ~r_wr_req_d;
    assign w_onehot = (habilita != 9'd0) && ((habilita & (habilita - 9'd1)) == 9'd0);
    assign listo_es = ~(r_pend | r_busy);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_is_wr_nxt  = r_is_wr;
        w_cmd_nxt    = r_cmd;
        w_wdata_nxt  = r_wdata;
        w_take_wr    = 1'b0;
        w_take_sweep = 1'b0;
        w_wr_done    = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_cmd_nxt = 1'b0;
                if (r_pend) begin
                    w_take_wr   = 1'b1;
                    w_idx_nxt   = r_cap_idx;
                    w_wdata_nxt = r_cap_data;
                    w_is_wr_nxt = 1'b1;
                    w_state_nxt = S_ADDR;
                end else if (r_sweep_pend) begin
                    w_take_sweep = 1'b1;
                    w_idx_nxt    = '0;
                    w_is_wr_nxt  = 1'b0;
                    w_state_nxt  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (r_cnt == PH_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ADDR_REC;
                end else w_cnt_nxt = r_cnt + 8'd1;
            end
            S_ADDR_REC: w_state_nxt = S_DATA;
            S_DATA: begin
                if (r_cnt == PH_LAST) begin
                    w_cnt_nxt   = '0;
                    w_sample    = !r_is_wr && !r_cmd;
                    w_state_nxt = S_DATA_REC;
                end else w_cnt_nxt = r_cnt + 8'd1;
            end
            S_DATA_REC: w_state_nxt = S_GAP;
            S_GAP: begin
                if (r_cmd) begin
                    w_cmd_nxt   = 1'b0;
                    w_wr_done   = r_is_wr;
                    w_state_nxt = S_IDLE;
                end else if (r_is_wr || r_idx == 4'd8) begin
                    if (CMD_EN) begin
                        w_cmd_nxt   = 1'b1;
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_wr_done   = r_is_wr;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = S_ADDR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they register glitch-free.
        w_wrdir     = w_is_wr_nxt | w_cmd_nxt;
        w_addr_nxt  = w_cmd_nxt ? CMD_BYTE : f_addr(w_idx_nxt);
        w_dbyte_nxt = w_cmd_nxt ? CMD_BYTE : w_wdata_nxt;
        w_cs_n_nxt  = 1'b1;
        w_rd_n_nxt  = 1'b1;
        w_wr_n_nxt  = 1'b1;
        w_a_d_nxt   = 1'b0;
        w_oe_nxt    = 1'b0;
        w_out_nxt   = '0;
        case (w_state_nxt)
            S_ADDR: begin
                w_cs_n_nxt = 1'b0; w_wr_n_nxt = 1'b0; w_oe_nxt = 1'b1; w_out_nxt = w_addr_nxt;
            end
            S_ADDR_REC: begin
                w_cs_n_nxt = 1'b0; w_a_d_nxt = 1'b1; w_oe_nxt = 1'b1; w_out_nxt = w_addr_nxt;
            end
            S_DATA: begin
                w_cs_n_nxt = 1'b0; w_a_d_nxt = 1'b1;
                if (w_wrdir) begin
                    w_wr_n_nxt = 1'b0; w_oe_nxt = 1'b1; w_out_nxt = w_dbyte_nxt;
                end else w_rd_n_nxt = 1'b0;
            end
            S_DATA_REC: begin
                w_cs_n_nxt = 1'b0; w_a_d_nxt = 1'b1;
                if (w_wrdir) begin
                    w_oe_nxt = 1'b1; w_out_nxt = w_dbyte_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0; r_idx <= '0; r_is_wr <= 1'b0; r_cmd <= 1'b0; r_wdata <= '0;
            r_wr_req_d <= 1'b0; r_pend <= 1'b0; r_busy <= 1'b0;
            r_cap_idx <= '0; r_cap_data <= '0;
            r_tmr <= '0; r_sweep_pend <= 1'b0;
            r_cs_n <= 1'b1; r_rd_n <= 1'b1; r_wr_n <= 1'b1; r_a_d <= 1'b0; r_oe <= 1'b0; r_out <= '0;
            for (int i = 0; i < 9; i++) r_le[i] <= '0;
        end else begin
            r_cnt <= w_cnt_nxt; r_idx <= w_idx_nxt; r_is_wr <= w_is_wr_nxt;
            r_cmd <= w_cmd_nxt; r_wdata <= w_wdata_nxt;
            r_wr_req_d <= wr_req;
            // A fresh valid request overrides whatever is queued, even on the cycle it is taken.
            if (w_take_wr) r_pend <= 1'b0;
            if (w_rise && w_onehot) begin
                r_pend     <= 1'b1;
                r_cap_idx  <= f_enc(habilita);
                r_cap_data <= w_vals[f_enc(habilita)];
            end
            if (w_take_wr)      r_busy <= 1'b1;
            else if (w_wr_done) r_busy <= 1'b0;
            r_tmr <= (r_tmr == DIV_LAST) ? 32'd0 : r_tmr + 32'd1;
            if (w_take_sweep)       r_sweep_pend <= 1'b0;
            if (r_tmr == DIV_LAST)  r_sweep_pend <= 1'b1;
            if (w_sample) r_le[r_idx] <= ad_in;
            r_cs_n <= w_cs_n_nxt; r_rd_n <= w_rd_n_nxt; r_wr_n <= w_wr_n_nxt;
            r_a_d  <= w_a_d_nxt;  r_oe   <= w_oe_nxt;   r_out  <= w_out_nxt;
        end
    end

    assign cs_n = r_cs_n;  assign rd_n  = r_rd_n;  assign wr_n   = r_wr_n;
    assign a_d  = r_a_d;   assign ad_oe = r_oe;    assign ad_out = r_out;
    assign anole      = r_le[0]; assign mesle      = r_le[1]; assign diale = r_le[2];
    assign horasle    = r_le[3]; assign minutosle  = r_le[4]; assign segundosle = r_le[5];
    assign htle       = r_le[6]; assign mtle       = r_le[7]; assign stle  = r_le[8];
endmodule

// File: tb/tb_rtc_bus_master.sv
// Self-checking bench for rtc_bus_master: RTC register-file model on the bus plus transaction-level expectations.
`timescale 1ns/1ps
module tb_rtc_bus_master;
    localparam int T_PH     = 2;
    localparam int READ_DIV = 600;
    localparam int ACC_LEN  = 2 * T_PH + 3;
`ifdef RTC_TRANSFER_CMD_EN
    localparam int CMD = 1;
`else
    localparam int CMD = 0;
`endif

    logic clk = 1'b0, reset = 1'b1, wr_req = 1'b0;
    logic [8:0] habilita = '0;
    logic [7:0] wv [9];
    logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
    logic listo_es, cs_n, rd_n, wr_n, a_d, ad_oe;
    logic [7:0] ad_out, ad_in;

    always #5 clk = ~clk;

    rtc_bus_master #(.T_PH(T_PH), .READ_DIV(READ_DIV)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .habilita(habilita),
        .ano(wv[0]), .mes(wv[1]), .dia(wv[2]), .horas(wv[3]), .minutos(wv[4]),
        .segundos(wv[5]), .ht(wv[6]), .mt(wv[7]), .st(wv[8]),
        .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle), .minutosle(minutosle),
        .segundosle(segundosle), .htle(htle), .mtle(mtle), .stle(stle),
        .listo_es(listo_es), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         rd;
        int         a_lo;
        int         d_lo;
        int         len;
    } txn_t;

    logic [7:0] MAP [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
    int checks = 0, failures = 0;

    // RTC chip model and bus monitor: latches address, stores writes, returns reads, logs cs_n windows.
    logic [7:0] mem [256];
    logic [7:0] rtc_addr = '0;
    bit   mem_ready = 0, in_win = 0;
    int   ovl = 0;
    txn_t q[$];
    txn_t cur;
    assign ad_in = mem[rtc_addr];

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'(a + 1);
            mem_ready = 1;
        end
        if (rd_n === 1'b0 && wr_n === 1'b0) ovl++;
        if (cs_n === 1'b0) begin
            if (!in_win) begin
                in_win = 1;
                cur = '{addr: 8'h00, data: 8'h00, rd: 0, a_lo: 0, d_lo: 0, len: 0};
            end
            cur.len++;
            if (!a_d && !wr_n) begin cur.a_lo++; cur.addr = ad_out; rtc_addr = ad_out; end
            if (a_d && !wr_n)  begin cur.d_lo++; cur.data = ad_out; mem[rtc_addr] = ad_out; end
            if (a_d && !rd_n)  begin cur.d_lo++; cur.rd = 1; cur.data = ad_in; end
        end else if (in_win) begin
            in_win = 0;
            q.push_back(cur);
        end
    end

    int rd_ptr = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_le(input int i);
        case (i)
            0: return anole;   1: return mesle;     2: return diale;
            3: return horasle; 4: return minutosle; 5: return segundosle;
            6: return htle;    7: return mtle;      default: return stle;
        endcase
    endfunction

    task automatic pop_txn(output txn_t t, output bit ok);
        t  = '{addr: 8'h00, data: 8'h00, rd: 0, a_lo: 0, d_lo: 0, len: 0};
        ok = 0;
        while (rd_ptr < q.size() && !ok) begin
            t = q[rd_ptr];
            rd_ptr++;
            if (!(CMD == 1 && t.addr == 8'hF0)) ok = 1;
        end
    endtask

    task automatic check_write_txn(input string tag, input int idx, input logic [7:0] val);
        txn_t t; bit ok;
        pop_txn(t, ok);
        chk({tag, "_present"}, 32'(ok), 1);
        chk({tag, "_addr"}, 32'(t.addr), 32'(MAP[idx]));
        chk({tag, "_data"}, 32'(t.data), 32'(val));
        chk({tag, "_dir"}, 32'(t.rd), 0);
        chk({tag, "_addr_lo"}, t.a_lo, T_PH);
        chk({tag, "_data_lo"}, t.d_lo, T_PH);
        chk({tag, "_cs_len"}, t.len, 2 * T_PH + 2);
        chk({tag, "_rtc_mem"}, 32'(mem[MAP[idx]]), 32'(val));
    endtask

    task automatic check_sweep_txns(input string tag);
        txn_t t; bit ok;
        for (int i = 0; i < 9; i++) begin
            pop_txn(t, ok);
            chk({tag, "_rd_present"}, 32'(ok), 1);
            chk({tag, "_rd_dir"}, 32'(t.rd), 1);
            chk({tag, "_rd_addr"}, 32'(t.addr), 32'(MAP[i]));
            chk({tag, "_rd_strobe"}, t.d_lo, T_PH);
        end
    endtask

    task automatic do_write(input string tag, input int idx, input logic [7:0] val);
        int n;
        wv[idx] = val; habilita = 9'(1 << idx); wr_req = 1'b1;
        tick();
        chk({tag, "_listo_drop"}, 32'(listo_es), 0);
        wr_req = 1'b0; n = 0;
        while (listo_es !== 1'b1 && n < 400) begin tick(); n++; end
        chk({tag, "_listo_cycles"}, n, ACC_LEN * (1 + CMD) + 1);
        check_write_txn(tag, idx, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx;
        bit saw_low;
        logic [7:0] val;
        logic [7:0] exp_le [9];
        for (int i = 0; i < 9; i++) wv[i] = '0;

        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_a_d", 32'(a_d), 0);
        chk("rst_ad_oe", 32'(ad_oe), 0);
        chk("rst_ad_out", 32'(ad_out), 0);
        chk("rst_listo", 32'(listo_es), 1);
        for (int i = 0; i < 9; i++) chk("rst_le", 32'(get_le(i)), 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_cs_n", 32'(cs_n), 1);
        chk("idle_listo", 32'(listo_es), 1);
        chk("idle_no_bus", q.size(), 0);

        // First automatic sweep: the RTC model returns address + 1.
        n = 0;
        while (q.size() - rd_ptr < 9 + CMD && n < 2000) begin tick(); n++; end
        repeat (20) tick();
        chk("sweep1_windows", q.size() - rd_ptr, 9 + CMD);
        check_sweep_txns("sweep1");
        for (int i = 0; i < 9; i++) chk("sweep1_le", 32'(get_le(i)), 32'(8'(MAP[i] + 8'd1)));

        do_write("wr_minutos", 4, 8'h45);

        for (int k = 0; k < 2; k++) begin
            habilita = (k == 0) ? 9'b000000011 : 9'b000000000;
            wr_req = 1'b1; saw_low = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (listo_es !== 1'b1) saw_low = 1;
                if (c == 1) wr_req = 1'b0;
            end
            chk("bad_hab_listo", 32'(saw_low), 0);
            chk("bad_hab_no_bus", q.size() - rd_ptr, 0);
        end

        for (int k = 0; k < 4; k++) begin
            idx = $urandom_range(0, 8);
            val = 8'($urandom);
            do_write("wr_rand", idx, val);
            repeat ($urandom_range(1, 6)) tick();
        end

        // Next sweep: a write requested while index 3 is being read waits for the sweep.
        rd_ptr = q.size(); n = 0;
        while (!(cs_n === 1'b0 && rd_n === 1'b0 && rtc_addr == 8'h23) && n < 1500) begin tick(); n++; end
        chk("mid_sweep_found", 32'(n < 1500), 1);
        for (int i = 0; i < 9; i++) exp_le[i] = mem[MAP[i]];
        idx = $urandom_range(0, 8);
        val = 8'($urandom);
        wv[idx] = val; habilita = 9'(1 << idx); wr_req = 1'b1;
        tick();
        chk("mid_listo_drop", 32'(listo_es), 0);
        wr_req = 1'b0; n = 0;
        while (listo_es !== 1'b1 && n < 400) begin tick(); n++; end
        chk("mid_listo_done", 32'(listo_es), 1);
        check_sweep_txns("sweep2");
        check_write_txn("mid_wr", idx, val);
        for (int i = 0; i < 9; i++) chk("sweep2_le", 32'(get_le(i)), 32'(exp_le[i]));

        // Reset in the data phase of a write aborts it completely.
        repeat (3) tick();
        idx = $urandom_range(0, 8);
        wv[idx] = 8'($urandom); habilita = 9'(1 << idx); wr_req = 1'b1;
        tick();
        wr_req = 1'b0; n = 0;
        while (!(a_d === 1'b1 && wr_n === 1'b0) && n < 50) begin tick(); n++; end
        chk("rstw_data_phase", 32'(n < 50), 1);
        reset = 1'b1;
        tick();
        chk("rstw_wr_n", 32'(wr_n), 1);
        chk("rstw_cs_n", 32'(cs_n), 1);
        chk("rstw_ad_oe", 32'(ad_oe), 0);
        chk("rstw_listo", 32'(listo_es), 1);
        chk("rstw_le", 32'(anole), 0);
        reset = 1'b0;
        repeat (2) tick();
        rd_ptr = q.size();
        repeat (40) tick();
        chk("rstw_no_retry", q.size() - rd_ptr, 0);
        chk("rstw_listo_after", 32'(listo_es), 1);
        chk("no_rd_wr_overlap", ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
